// File: rtl/gate_sweep_ctrl.sv
// Exhaustive sweep sequencer for a single combinational gate-under-test.
// Drives every input vector, waits SETTLE cycles, and compares against a selectable reference.
module gate_sweep_ctrl #(
  parameter int unsigned N_IN   = 2,
  parameter int unsigned SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op_sel,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_cnt,
  output logic [N_IN-1:0] first_err_vec,
  output logic            first_err_valid
);

  localparam int unsigned CW = 4;
  localparam int unsigned EW = N_IN + 1;

  typedef enum logic [1:0] {S_IDLE, S_HOLD, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [2:0]      op_q, op_d;
  logic [N_IN-1:0] vec_q, vec_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [EW-1:0]   err_q, err_d;
  logic [N_IN-1:0] fvec_q, fvec_d;
  logic            fval_q, fval_d;
  logic            pass_q, pass_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ref_bit;
  logic            mism;

  // Reference value for the vector currently on the GUT
  always_comb begin
    ref_bit = 1'b0;
    case (op_q)
      3'd0: ref_bit = vec_q[0];
      3'd1: ref_bit = ~vec_q[0];
      3'd2: ref_bit = &vec_q;
      3'd3: ref_bit = |vec_q;
      3'd4: ref_bit = ~&vec_q;
      3'd5: ref_bit = ~|vec_q;
      3'd6: ref_bit = ^vec_q;
      3'd7: ref_bit = ~^vec_q;
      default: ref_bit = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      vec_q   <= '0;
      cnt_q   <= '0;
      err_q   <= '0;
      fvec_q  <= '0;
      fval_q  <= 1'b0;
      pass_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      fvec_q  <= fvec_d;
      fval_q  <= fval_d;
      pass_q  <= pass_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    fvec_d  = fvec_q;
    fval_d  = fval_q;
    pass_d  = pass_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    mism    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op_sel;
          vec_d   = '0;
          cnt_d   = CW'(SETTLE - 1);
          err_d   = '0;
          fval_d  = 1'b0;
          pass_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          mism = (dut_out != ref_bit);
          if (mism) begin
            err_d = err_q + EW'(1);
            if (!fval_q) begin
              fvec_d = vec_q;
              fval_d = 1'b1;
            end
          end
          // Last vector: pass reflects the count including this compare
          if (&vec_q) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end else begin
            vec_d = vec_q + N_IN'(1);
            cnt_d = CW'(SETTLE - 1);
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign dut_in          = vec_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign pass            = pass_q;
  assign err_cnt         = err_q;
  assign first_err_vec   = fvec_q;
  assign first_err_valid = fval_q;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl with a GUT model and a result scoreboard.
module tb_gate_sweep_ctrl;

  localparam int unsigned N  = 3;
  localparam int unsigned ST = 2;
  localparam int unsigned NV = 1 << N;
  localparam int unsigned SWEEP = NV * ST;

  typedef struct {
    int unsigned err;
    int unsigned fvec;
    bit          fval;
    bit          pass;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [2:0]   op_sel;
  logic [N-1:0] dut_in;
  logic         dut_out;
  logic         busy;
  logic         done;
  logic         pass;
  logic [N:0]   err_cnt;
  logic [N-1:0] first_err_vec;
  logic         first_err_valid;

  int   gut_mode;
  logic [2:0] gut_op;
  int   checks;
  int   passed;
  exp_t sb[$];

  gate_sweep_ctrl #(.N_IN(N), .SETTLE(ST)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_sel(op_sel),
    .dut_in(dut_in), .dut_out(dut_out), .busy(busy), .done(done),
    .pass(pass), .err_cnt(err_cnt), .first_err_vec(first_err_vec),
    .first_err_valid(first_err_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_fn(input logic [2:0] op, input logic [N-1:0] v);
    case (op)
      3'd0: return v[0];
      3'd1: return ~v[0];
      3'd2: return &v;
      3'd3: return |v;
      3'd4: return ~&v;
      3'd5: return ~|v;
      3'd6: return ^v;
      default: return ~^v;
    endcase
  endfunction

  // GUT models: 0 correct, 1 OR gate, 2 stuck-at-0, 3 inverted reference, 4 inverter on in[0]
  function automatic logic gut_fn(input int mode, input logic [2:0] op, input logic [N-1:0] v);
    case (mode)
      0: return ref_fn(op, v);
      1: return |v;
      2: return 1'b0;
      3: return ~ref_fn(op, v);
      default: return ~v[0];
    endcase
  endfunction

  always_comb dut_out = gut_fn(gut_mode, gut_op, dut_in);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic push_exp(input logic [2:0] op, input int mode);
    exp_t e;
    e.err = 0; e.fvec = 0; e.fval = 0;
    for (int v = 0; v < NV; v++) begin
      if (gut_fn(mode, op, N'(v)) !== ref_fn(op, N'(v))) begin
        if (!e.fval) begin
          e.fvec = v;
          e.fval = 1'b1;
        end
        e.err++;
      end
    end
    e.pass = (e.err == 0);
    sb.push_back(e);
  endtask

  // Called #1 after the accepting edge; returns #1 after the done edge
  task automatic wait_sweep(input bit disturb);
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int c = 1; c <= SWEEP + 8; c++) begin
      @(posedge clk); #1;
      if (disturb && c == 5) begin
        op_sel = ~op_sel;
        start  = 1'b1;
      end
      if (disturb && c == 7) start = 1'b0;
      if (done) begin
        seen = 1'b1;
        chk("done_edge", c, SWEEP);
        chk("busy_at_done", busy, 0);
        chk("dut_in_at_done", dut_in, NV - 1);
        if (sb.size() == 0) chk("sb_empty", 0, 1);
        else begin
          e = sb.pop_front();
          chk("err_cnt", err_cnt, e.err);
          chk("first_err_valid", first_err_valid, e.fval);
          if (e.fval) chk("first_err_vec", first_err_vec, e.fvec);
          chk("pass", pass, e.pass);
        end
        break;
      end
      chk("dut_in_hold", dut_in, c / ST);
      chk("busy_hold", busy, 1);
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic sweep(input logic [2:0] op, input int mode, input bit disturb, input bit hold);
    @(negedge clk);
    op_sel   = op;
    gut_op   = op;
    gut_mode = mode;
    push_exp(op, mode);
    if (hold) push_exp(op, mode);
    start = 1'b1;
    @(posedge clk); #1;
    chk("busy_accept", busy, 1);
    chk("dut_in_accept", dut_in, 0);
    if (!hold) start = 1'b0;
    wait_sweep(disturb);
    @(posedge clk); #1;
    chk("done_pulse_end", done, 0);
    if (hold) begin
      chk("busy_in_idle", busy, 0);
      @(posedge clk); #1;
      chk("reaccept_busy", busy, 1);
      chk("reaccept_dut_in", dut_in, 0);
      start = 1'b0;
      wait_sweep(1'b0);
      @(posedge clk); #1;
      chk("done_pulse_end2", done, 0);
    end
    chk("dut_in_held", dut_in, NV - 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_dut_in"}, dut_in, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_err_cnt"}, err_cnt, 0);
    chk({tag, "_first_err_vec"}, first_err_vec, 0);
    chk({tag, "_first_err_valid"}, first_err_valid, 0);
  endtask

  initial begin
    bit saw_done;
    checks = 0; passed = 0;
    rst_n = 1'b0; start = 1'b0; op_sel = 3'd0;
    gut_mode = 0; gut_op = 3'd0;
    #12;
    chk_zero("reset");
    @(negedge clk); rst_n = 1'b1;

    sweep(3'd1, 0, 1'b0, 1'b0);  // NOT, correct GUT
    sweep(3'd2, 1, 1'b0, 1'b0);  // AND vs OR gate
    sweep(3'd3, 2, 1'b0, 1'b0);  // OR vs stuck-at-0
    sweep(3'd5, 2, 1'b0, 1'b0);  // NOR vs stuck-at-0, results cleared on restart
    sweep(3'd6, 3, 1'b0, 1'b0);  // every vector fails: counter maximum
    sweep(3'd7, 0, 1'b1, 1'b0);  // mid-sweep op_sel/start changes ignored

    // Abort during vector 2
    @(negedge clk);
    op_sel = 3'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2 * ST) @(posedge clk);
    #2;
    chk("vec2_before_reset", dut_in, 2);
    rst_n = 1'b0;
    #1;
    chk_zero("async_reset");
    @(negedge clk); rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (SWEEP + 4) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    chk("no_done_after_abort", saw_done, 0);

    sweep(3'd4, 4, 1'b0, 1'b0);  // NAND vs inverter, fresh start from 000
    sweep(3'd0, 0, 1'b0, 1'b1);  // BUF, start held: back-to-back sweeps

    chk("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
